// File: rtl/int_to_fp_serial.sv
// Iterative integer -> IEEE-754 converter: normalises one bit per clock, packs with truncation.
// Result and inexact flag are registered and held until the consumer handshakes.
module int_to_fp_serial #(
  parameter int N    = 32,
  parameter int M    = 23,
  parameter int P    = N - M - 1,
  parameter int W    = 32,
  parameter int BIAS = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_inexact
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t         state;
  logic [W-1:0]   mag;
  logic           sgn;
  logic [P:0]     e;

  logic           neg_in;
  logic [W-1:0]   mag_in;
  logic [M-1:0]   mant;
  logic           inexact;
  logic [P-1:0]   exp_field;

  assign in_ready  = (state == IDLE) & ~rst;
  assign neg_in    = in_signed & in_data[W-1];
  // Negating the most negative value wraps to 2^(W-1), which is the correct magnitude.
  assign mag_in    = neg_in ? (~in_data + W'(1)) : in_data;
  assign exp_field = P'(e) + P'(BIAS);

  generate
    if (W - 1 >= M) begin : g_mant_slice
      assign mant = mag[W-2 -: M];
    end else begin : g_mant_pad
      assign mant = {mag[W-2:0], {(M-W+1){1'b0}}};
    end
    if (W - 1 > M) begin : g_inexact
      assign inexact = |mag[W-2-M:0];
    end else begin : g_exact
      assign inexact = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
      mag         <= '0;
      sgn         <= 1'b0;
      e           <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn <= neg_in;
          mag <= mag_in;
          e   <= (P+1)'(W - 1);
          if (mag_in == '0) begin
            // Zero bypasses NORM; out_valid is raised on the first DONE cycle.
            out_data    <= '0;
            out_inexact <= 1'b0;
            state       <= DONE;
          end else begin
            state <= NORM;
          end
        end
        NORM: if (mag[W-1]) begin
          out_data    <= {sgn, exp_field, mant};
          out_inexact <= inexact;
          out_valid   <= 1'b1;
          state       <= DONE;
        end else begin
          mag <= mag << 1;
          e   <= e - (P+1)'(1);
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_serial.sv
// Directed + randomized bench for int_to_fp_serial against an arithmetic reference model.
module tb_int_to_fp_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_inexact;
  logic [31:0] out_data;

  int total = 0;
  int passes = 0;

  always #5 clk = ~clk;

  int_to_fp_serial dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: value -> sign/magnitude, locate MSB, truncate below the 23-bit fraction.
  function automatic void model(input logic [31:0] d, input logic s,
                                output logic [31:0] f, output logic inx, output int lat);
    logic              sg;
    longint unsigned   mg, mant, expv;
    int                p;
    sg = s && d[31];
    mg = sg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    if (mg == 0) begin
      f = 32'd0; inx = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mg[i]) p = i;
    expv = longint'(p) + 127;
    mant = (p >= 23) ? (mg >> (p - 23)) : (mg << (23 - p));
    mant = mant % (64'd1 << 23);
    inx  = (p > 23) && ((mg % (64'd1 << (p - 23))) != 0);
    f    = {sg, expv[7:0], mant[22:0]};
    lat  = 1 + (31 - p);
  endfunction

  task automatic run(input logic [31:0] d, input logic s,
                     output logic [31:0] f, output logic inx, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_signed = s;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 40) chk("result_timeout", 0, 1);
    f = out_data; inx = out_inexact;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("out_valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input logic s,
                          input logic [31:0] ef, input logic einx, input int elat);
    logic [31:0] f; logic inx; int lat;
    run(d, s, f, inx, lat);
    chk({tag, "_data"}, f, ef);
    chk({tag, "_inexact"}, inx, einx);
    if (elat > 0) chk({tag, "_latency"}, lat, elat);
    handshake();
  endtask

  initial begin
    logic [31:0] f, rf, held, d;
    logic        inx, rinx, s;
    int          lat, rlat;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_inexact", out_inexact, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    directed("u_one",   32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 32);
    directed("u_carry", 32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 8);
    directed("u_max",   32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 1'b1, 1);
    directed("s_m1",    32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 32);
    directed("s_min",   32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 1);
    directed("zero",    32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1);

    // Backpressure: result must be held while in_valid pulses are ignored.
    run(32'd1000, 1'b0, held, inx, lat);
    chk("bp_first_data", held, 32'h447A_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0]; in_data = $urandom; in_signed = 1'b1;
      @(posedge clk);
      #1 chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake();
    model(32'hFFFF_F000, 1'b1, rf, rinx, rlat);
    run(32'hFFFF_F000, 1'b1, f, inx, lat);
    chk("b2b_data", f, rf);
    chk("b2b_latency", lat, rlat);
    chk("b2b_data_const", f, 32'hC580_0000);
    handshake();
    chk("data_kept_after_hs", out_data, 32'hC580_0000);

    // Reset in the middle of normalisation aborts the word.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001; in_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_inexact", out_inexact, 0);
    rst = 1'b0;
    #1 chk("mid_rst_in_ready_after", in_ready, 1);
    directed("after_rst", 32'h0000_0002, 1'b0, 32'h4000_0000, 1'b0, 31);

    // Randomized words with spread leading-zero counts.
    for (int i = 0; i < 40; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) d = ~d;
      s = 1'($urandom_range(0, 1));
      model(d, s, rf, rinx, rlat);
      run(d, s, f, inx, lat);
      chk("rand_data", f, rf);
      chk("rand_inexact", inx, rinx);
      chk("rand_latency", lat, rlat);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1 chk("rand_hold", out_data, rf);
        end
      end
      handshake();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
